// File: rtl/sum_display_pkg.sv
//------------------------------------------------------------------------------
// Module      : sum_display_pkg
// Description : Shared FSM encoding, 7-segment codes and digit selects.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sum_display_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_NONE  = 2'b00;
  localparam logic [1:0] DIG_UNITS = 2'b01;
  localparam logic [1:0] DIG_TENS  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/sum_display_driver_bcd_to_seg7.sv
//------------------------------------------------------------------------------
// Module      : bcd_to_seg7
// Description : Combinational BCD digit to 7-segment decoder; non-BCD codes blank.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_to_seg7
  import sum_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sum_display_driver.sv
//------------------------------------------------------------------------------
// Module      : sum_display_driver
// Description : Accepts an adder sum, converts it to BCD by double-dabble and
//               drives a two-digit multiplexed 7-segment display.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sum_display_driver
  import sum_display_pkg::*;
#(
  parameter int SUM_W       = 5,
  parameter int REFRESH_DIV = 1024
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [1:0]       digit_sel
);

  localparam int SR_W  = SUM_W + 8;
  localparam int CNT_W = $clog2(SUM_W + 1);
  localparam int RC_W  = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] c_last_iter   = CNT_W'(SUM_W - 1);
  localparam logic [RC_W-1:0]  c_refresh_max = RC_W'(REFRESH_DIV - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_xfer;
  logic              w_load;

  logic [SR_W-1:0]   r_shift;
  logic [SR_W-1:0]   w_dabbled;
  logic [SR_W-1:0]   w_shifted;
  logic [CNT_W-1:0]  r_iter;
  logic              r_carry_pend;

  logic [3:0]        r_tens;
  logic [3:0]        r_units;
  logic              r_carry;
  logic [3:0]        w_tens_next;
  logic [3:0]        w_units_next;
  logic              w_carry_next;

  logic [RC_W-1:0]   r_refresh_cnt;
  logic              w_wrap;
  logic              r_sel_units;
  logic              w_sel_units_next;

  logic [3:0]        w_digit;
  logic [6:0]        w_dec_seg;
  logic [6:0]        w_seg_next;
  logic              w_dp_next;
  logic [1:0]        w_digit_sel_next;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [1:0]        r_digit_sel;

  assign sum_ready = (r_state == IDLE);
  assign w_xfer    = sum_valid & sum_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (r_iter == c_last_iter) begin
          w_load       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Double-dabble step: correct each BCD nibble, then shift the whole register
  always_comb begin
    w_dabbled = r_shift;
    if (r_shift[SUM_W+3 -: 4] >= 4'd5) begin
      w_dabbled[SUM_W+3 -: 4] = r_shift[SUM_W+3 -: 4] + 4'd3;
    end
    if (r_shift[SUM_W+7 -: 4] >= 4'd5) begin
      w_dabbled[SUM_W+7 -: 4] = r_shift[SUM_W+7 -: 4] + 4'd3;
    end
  end

  assign w_shifted = w_dabbled << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= '0;
      r_iter       <= '0;
      r_carry_pend <= 1'b0;
    end else if (w_xfer) begin
      r_shift      <= {8'b0, sum_in};
      r_iter       <= '0;
      r_carry_pend <= sum_in[SUM_W-1];
    end else if (r_state == CONVERT) begin
      r_shift      <= w_shifted;
      r_iter       <= r_iter + CNT_W'(1);
    end
  end

  // Carry is held as pending until the digits load so the display never shows a mixed value
  assign w_tens_next  = w_load ? w_shifted[SUM_W+7 -: 4] : r_tens;
  assign w_units_next = w_load ? w_shifted[SUM_W+3 -: 4] : r_units;
  assign w_carry_next = w_load ? r_carry_pend            : r_carry;

  assign w_wrap           = (r_refresh_cnt == c_refresh_max);
  assign w_sel_units_next = w_wrap ? ~r_sel_units : r_sel_units;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens        <= 4'd0;
      r_units       <= 4'd0;
      r_carry       <= 1'b0;
      r_refresh_cnt <= '0;
      r_sel_units   <= 1'b1;
    end else begin
      r_tens        <= w_tens_next;
      r_units       <= w_units_next;
      r_carry       <= w_carry_next;
      r_refresh_cnt <= w_wrap ? '0 : r_refresh_cnt + RC_W'(1);
      r_sel_units   <= w_sel_units_next;
    end
  end

  assign w_digit = w_sel_units_next ? w_units_next : w_tens_next;

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd (w_digit),
    .seg (w_dec_seg)
  );

  // Outputs are computed from next-state values so digit, segments and dp switch together
  always_comb begin
    w_seg_next       = w_dec_seg;
    w_dp_next        = w_carry_next;
    w_digit_sel_next = DIG_UNITS;
    if (!w_sel_units_next) begin
      w_seg_next       = (w_tens_next == 4'd0) ? SEG_BLANK : w_dec_seg;
      w_dp_next        = 1'b0;
      w_digit_sel_next = DIG_TENS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b0;
      r_digit_sel <= DIG_NONE;
    end else begin
      r_seg       <= w_seg_next;
      r_dp        <= w_dp_next;
      r_digit_sel <= w_digit_sel_next;
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign digit_sel = r_digit_sel;

endmodule

`default_nettype wire

// File: tb/tb_sum_display_driver.sv
//------------------------------------------------------------------------------
// Module      : tb_sum_display_driver
// Description : Scoreboard bench for sum_display_driver with directed sums.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sum_display_driver;

  localparam int SUM_W       = 5;
  localparam int REFRESH_DIV = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic [SUM_W-1:0] sum_in    = '0;
  logic             sum_valid = 1'b0;
  logic             sum_ready;
  logic [6:0]       seg;
  logic             dp;
  logic [1:0]       digit_sel;

  typedef struct packed {
    logic [6:0] seg_u;
    logic       dp_u;
    logic [6:0] seg_t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sum_display_driver #(
    .SUM_W       (SUM_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_digit(input string tag, input exp_t e);
    if (digit_sel == 2'b01)
      check({tag, "_units"}, 16'({seg, dp}), 16'({e.seg_u, e.dp_u}));
    else if (digit_sel == 2'b10)
      check({tag, "_tens"}, 16'({seg, dp}), 16'({e.seg_t, 1'b0}));
    else
      check({tag, "_digit_sel"}, 16'(digit_sel), 16'(2'b01));
  endtask

  // Monitor: a result is presented when sum_ready returns high outside reset
  initial begin : monitor
    logic       prev_ready;
    int         low_cnt;
    exp_t       e;
    logic [1:0] first_sel;
    bit         seen;
    prev_ready = 1'b1;
    low_cnt    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ready = 1'b1;
        low_cnt    = 0;
      end else if (!sum_ready) begin
        low_cnt++;
        prev_ready = 1'b0;
      end else begin
        if (!prev_ready) begin
          check("ready_low_cycles", 16'(low_cnt), 16'(SUM_W));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got a completion, required none");
          end else begin
            e = exp_q.pop_front();
            check_digit("first", e);
            first_sel = digit_sel;
            seen      = 1'b0;
            for (int i = 0; i < 3 * REFRESH_DIV && !seen; i++) begin
              @(negedge clk);
              if (digit_sel != first_sel) seen = 1'b1;
            end
            if (seen) begin
              check_digit("second", e);
            end else begin
              checks++;
              errors++;
              $display("FAIL second_digit: digit_sel stuck at %0b, required a toggle", first_sel);
            end
          end
        end
        prev_ready = 1'b1;
        low_cnt    = 0;
      end
    end
  end

  task automatic send(input logic [SUM_W-1:0] v);
    sum_in    = v;
    sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!sum_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!sum_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: sum_ready=%0b, required 1", sum_ready);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin : stimulus
    logic [1:0] s;
    int         n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_seg",       16'(seg),       16'(7'h00));
    check("rst_dp",        16'(dp),        16'(1'b0));
    check("rst_digit_sel", 16'(digit_sel), 16'(2'b00));
    check("rst_ready",     16'(sum_ready), 16'(1'b1));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_digit_sel", 16'(digit_sel), 16'(2'b01));
    check("post_rst_seg",       16'(seg),       16'(7'h3F));
    check("post_rst_dp",        16'(dp),        16'(1'b0));

    // 27 -> "27" with carry
    exp_q.push_back('{seg_u: 7'h07, dp_u: 1'b1, seg_t: 7'h5B});
    send(5'd27);
    wait_idle();

    // 5 -> blank tens
    exp_q.push_back('{seg_u: 7'h6D, dp_u: 1'b0, seg_t: 7'h00});
    send(5'd5);
    wait_idle();

    // 18, with a 9 offered while busy that must be ignored
    exp_q.push_back('{seg_u: 7'h7F, dp_u: 1'b1, seg_t: 7'h06});
    send(5'd18);
    sum_in    = 5'd9;
    sum_valid = 1'b1;
    repeat (3) @(negedge clk);
    sum_valid = 1'b0;
    wait_idle();

    // 31 aborted by reset in its third conversion cycle
    send(5'd31);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_seg",       16'(seg),       16'(7'h00));
    check("midrst_dp",        16'(dp),        16'(1'b0));
    check("midrst_digit_sel", 16'(digit_sel), 16'(2'b00));
    check("midrst_ready",     16'(sum_ready), 16'(1'b1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_digit_sel", 16'(digit_sel), 16'(2'b01));
    check("after_rst_seg",       16'(seg),       16'(7'h3F));
    check("after_rst_dp",        16'(dp),        16'(1'b0));
    check("after_rst_ready",     16'(sum_ready), 16'(1'b1));
    exp_q.push_back('{seg_u: 7'h06, dp_u: 1'b1, seg_t: 7'h4F});
    send(5'd31);
    wait_idle();

    // Refresh period, then align a completion onto a wrap edge
    s = digit_sel;
    n = 0;
    while (digit_sel == s && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      s = digit_sel;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (digit_sel == s && n < 20);
      check("refresh_period", 16'(n), 16'(REFRESH_DIV));
    end
    repeat (2) @(negedge clk);
    exp_q.push_back('{seg_u: 7'h5B, dp_u: 1'b0, seg_t: 7'h06});
    send(5'd12);
    wait_idle();

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pending_results", 16'(exp_q.size()), 16'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
